board_writer: RTL and testbench

- Owns the playfield cell store and is its write-side engine: it accepts piece-lock commits from game logic, writes the four cells, then detects full rows and collapses them.
- It also serves the video manager's combinational cell read port: row/column selector in, 3-bit block type out.
- It sits between game logic (producer of commits) and the pixel manager (consumer of cell types).

---
 rtl/board_writer.sv | 229 ++++++++++++++++++++++
 tb/tb_board_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_writer.sv
// Playfield cell store with its write-side engine: places piece-lock commits,
// detects full rows and collapses them, and serves a combinational cell read port.
module board_writer #(
    parameter int BLOCKS_VERTICAL   = 11,
    parameter int BLOCKS_HORIZONTAL = 22,
    parameter int CELLS_PER_COMMIT  = 4
) (
    input  logic                            clk_25_175,
    input  logic                            reset,
    input  logic [4:0]                      memselector_v,
    input  logic [4:0]                      memselector_h,
    output logic [2:0]                      blocktype_mem,
    input  logic                            commit_valid,
    output logic                            commit_ready,
    input  logic [2:0]                      commit_type,
    input  logic [5*CELLS_PER_COMMIT-1:0]   commit_v,
    input  logic [5*CELLS_PER_COMMIT-1:0]   commit_h,
    input  logic                            clear_all,
    output logic                            busy,
    output logic                            clear_done,
    output logic [2:0]                      clear_count
);

    localparam int ROW_W = $clog2(BLOCKS_VERTICAL);
    localparam int COL_W = $clog2(BLOCKS_HORIZONTAL);
    localparam int K_W   = $clog2(CELLS_PER_COMMIT);
    localparam logic [4:0]       ROWS_5    = 5'(BLOCKS_VERTICAL);
    localparam logic [4:0]       COLS_5    = 5'(BLOCKS_HORIZONTAL);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(BLOCKS_VERTICAL - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO  = {ROW_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
    localparam logic [K_W-1:0]   LAST_K    = K_W'(CELLS_PER_COMMIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        SCAN  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [2:0]         board_r [BLOCKS_VERTICAL][BLOCKS_HORIZONTAL];
    logic [2:0]         lat_type_r;
    logic [4:0]         lat_v_r [CELLS_PER_COMMIT];
    logic [4:0]         lat_h_r [CELLS_PER_COMMIT];
    logic [K_W-1:0]     k_r;
    logic [ROW_W-1:0]   r_r;
    logic [ROW_W-1:0]   s_r;
    logic [ROW_W-1:0]   s_prev_s;
    logic [2:0]         clear_count_r;
    logic               commit_ready_r;
    logic               busy_r;
    logic               clear_done_r;
    logic               accept_s;
    logic               row_full_s;
    logic [4:0]         cell_v_s;
    logic [4:0]         cell_h_s;
    logic               cell_we_s;

    // Read port: live storage, zero for any selector off the board
    always_comb begin
        if ((memselector_v < ROWS_5) && (memselector_h < COLS_5)) begin
            blocktype_mem = board_r[memselector_v[ROW_W-1:0]][memselector_h[COL_W-1:0]];
        end else begin
            blocktype_mem = 3'd0;
        end
    end

    // Current write cell, its legality, and fullness of the row under scan
    always_comb begin
        cell_v_s   = lat_v_r[k_r];
        cell_h_s   = lat_h_r[k_r];
        cell_we_s  = (state_r == WRITE) && (cell_v_s < ROWS_5) && (cell_h_s < COLS_5)
                     && (lat_type_r != 3'd0);
        s_prev_s   = s_r - ROW_ONE;
        row_full_s = 1'b1;
        for (int c = 0; c < BLOCKS_HORIZONTAL; c++) begin
            row_full_s = row_full_s & (board_r[r_r][c] != 3'd0);
        end
    end

    // Next-state logic; clear_all overrides everything including a pending accept
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        if (clear_all) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (commit_valid) begin
                        state_next_s = WRITE;
                        accept_s     = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                WRITE: begin
                    if (k_r == LAST_K) begin
                        state_next_s = SCAN;
                    end else begin
                        state_next_s = WRITE;
                    end
                end
                SCAN: begin
                    if (row_full_s) begin
                        state_next_s = SHIFT;
                    end else if (r_r == ROW_ZERO) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = SCAN;
                    end
                end
                SHIFT: begin
                    if (s_r == ROW_ZERO) begin
                        state_next_s = SCAN;
                    end else begin
                        state_next_s = SHIFT;
                    end
                end
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register and registered handshake/status outputs
    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            commit_ready_r <= 1'b1;
            busy_r         <= 1'b0;
            clear_done_r   <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            commit_ready_r <= (state_next_s == IDLE);
            busy_r         <= (state_next_s != IDLE);
            clear_done_r   <= (state_next_s == DONE);
        end
    end

    // Datapath: latch commit, write cells, collapse rows; rescan stays at r after a shift
    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < BLOCKS_VERTICAL; v++) begin
                for (int h = 0; h < BLOCKS_HORIZONTAL; h++) begin
                    board_r[v][h] <= 3'd0;
                end
            end
            for (int i = 0; i < CELLS_PER_COMMIT; i++) begin
                lat_v_r[i] <= 5'd0;
                lat_h_r[i] <= 5'd0;
            end
            lat_type_r    <= 3'd0;
            k_r           <= {K_W{1'b0}};
            r_r           <= ROW_ZERO;
            s_r           <= ROW_ZERO;
            clear_count_r <= 3'd0;
        end else if (clear_all) begin
            for (int v = 0; v < BLOCKS_VERTICAL; v++) begin
                for (int h = 0; h < BLOCKS_HORIZONTAL; h++) begin
                    board_r[v][h] <= 3'd0;
                end
            end
            clear_count_r <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        for (int i = 0; i < CELLS_PER_COMMIT; i++) begin
                            lat_v_r[i] <= commit_v[5*i +: 5];
                            lat_h_r[i] <= commit_h[5*i +: 5];
                        end
                        lat_type_r    <= commit_type;
                        k_r           <= {K_W{1'b0}};
                        clear_count_r <= 3'd0;
                    end
                end
                WRITE: begin
                    if (cell_we_s) begin
                        board_r[cell_v_s[ROW_W-1:0]][cell_h_s[COL_W-1:0]] <= lat_type_r;
                    end
                    if (k_r == LAST_K) begin
                        r_r <= LAST_ROW;
                    end else begin
                        k_r <= k_r + K_W'(1);
                    end
                end
                SCAN: begin
                    if (row_full_s) begin
                        s_r <= r_r;
                    end else if (r_r != ROW_ZERO) begin
                        r_r <= r_r - ROW_ONE;
                    end
                end
                SHIFT: begin
                    for (int c = 0; c < BLOCKS_HORIZONTAL; c++) begin
                        if (s_r == ROW_ZERO) begin
                            board_r[s_r][c] <= 3'd0;
                        end else begin
                            board_r[s_r][c] <= board_r[s_prev_s][c];
                        end
                    end
                    if (s_r == ROW_ZERO) begin
                        if (clear_count_r != 3'd7) begin
                            clear_count_r <= clear_count_r + 3'd1;
                        end
                    end else begin
                        s_r <= s_prev_s;
                    end
                end
                DONE: begin
                    k_r <= {K_W{1'b0}};
                end
                default: begin
                    k_r <= {K_W{1'b0}};
                end
            endcase
        end
    end

    assign commit_ready = commit_ready_r;
    assign busy         = busy_r;
    assign clear_done   = clear_done_r;
    assign clear_count  = clear_count_r;

endmodule

// File: tb/tb_board_writer.sv
// Randomized self-checking bench for board_writer against a row-compaction
// reference model of the playfield.
module tb_board_writer;

    logic        clk_25_175 = 1'b0;
    logic        reset;
    logic [4:0]  memselector_v;
    logic [4:0]  memselector_h;
    logic [2:0]  blocktype_mem;
    logic        commit_valid;
    logic        commit_ready;
    logic [2:0]  commit_type;
    logic [19:0] commit_v;
    logic [19:0] commit_h;
    logic        clear_all;
    logic        busy;
    logic        clear_done;
    logic [2:0]  clear_count;

    int vectors     = 0;
    int miscompares = 0;
    int model [11][22];
    int exp_latency;
    int exp_count;

    board_writer dut (
        .clk_25_175    (clk_25_175),
        .reset         (reset),
        .memselector_v (memselector_v),
        .memselector_h (memselector_h),
        .blocktype_mem (blocktype_mem),
        .commit_valid  (commit_valid),
        .commit_ready  (commit_ready),
        .commit_type   (commit_type),
        .commit_v      (commit_v),
        .commit_h      (commit_h),
        .clear_all     (clear_all),
        .busy          (busy),
        .clear_done    (clear_done),
        .clear_count   (clear_count)
    );

    always #20 clk_25_175 = ~clk_25_175;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic model_zero();
        for (int v = 0; v < 11; v++)
            for (int h = 0; h < 22; h++)
                model[v][h] = 0;
        exp_count = 0;
    endtask

    // Reference: place cells, drop every full row, pack survivors to the bottom.
    // Latency: 4 writes + 11 base scans + one rescan per full row; a full row found at
    // original row f with j full rows beneath it sits at f+j when removed.
    task automatic model_apply(input int t, input logic [19:0] vv, input logic [19:0] hh);
        bit full [11];
        int nfull, shifts, j, dst;
        int nb [11][22];
        for (int k = 0; k < 4; k++) begin
            int cv, ch;
            cv = int'(vv[5*k +: 5]);
            ch = int'(hh[5*k +: 5]);
            if (cv < 11 && ch < 22 && t != 0) model[cv][ch] = t;
        end
        nfull = 0; shifts = 0; j = 0;
        for (int r = 10; r >= 0; r--) begin
            full[r] = 1'b1;
            for (int h = 0; h < 22; h++) if (model[r][h] == 0) full[r] = 1'b0;
            if (full[r]) begin
                shifts += r + j + 1;
                j++;
                nfull++;
            end
        end
        for (int v = 0; v < 11; v++) for (int h = 0; h < 22; h++) nb[v][h] = 0;
        dst = 10;
        for (int r = 10; r >= 0; r--) begin
            if (!full[r]) begin
                for (int h = 0; h < 22; h++) nb[dst][h] = model[r][h];
                dst--;
            end
        end
        model = nb;
        exp_latency = 4 + 11 + nfull + shifts;
        exp_count   = (nfull > 7) ? 7 : nfull;
    endtask

    task automatic check_board(input string tag);
        for (int v = 0; v < 11; v++) begin
            for (int h = 0; h < 22; h++) begin
                memselector_v = 5'(v);
                memselector_h = 5'(h);
                #1;
                check(tag, blocktype_mem, model[v][h]);
            end
        end
        memselector_v = 5'd11; memselector_h = 5'd0;  #1; check("oob_row", blocktype_mem, 0);
        memselector_v = 5'd0;  memselector_h = 5'd22; #1; check("oob_col", blocktype_mem, 0);
        memselector_v = 5'd31; memselector_h = 5'd31; #1; check("oob_both", blocktype_mem, 0);
    endtask

    task automatic issue_commit(input int t, input logic [19:0] vv, input logic [19:0] hh);
        @(negedge clk_25_175);
        check("ready_before", commit_ready, 1);
        commit_valid = 1'b1;
        commit_type  = 3'(t);
        commit_v     = vv;
        commit_h     = hh;
        @(posedge clk_25_175);
        #1;
        commit_valid = 1'b0;
        commit_type  = 3'($urandom);
        commit_v     = 20'($urandom);
        commit_h     = 20'($urandom);
        model_apply(t, vv, hh);
    endtask

    task automatic finish_commit(input string tag);
        int  n;
        bit  seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 2000) begin
            @(posedge clk_25_175);
            n++;
            @(negedge clk_25_175);
            if (clear_done) seen = 1'b1;
        end
        check("done_latency", seen ? n : -1, exp_latency);
        check("clear_count", clear_count, exp_count);
        @(negedge clk_25_175);
        check("done_one_cycle", clear_done, 0);
        check("ready_after", commit_ready, 1);
        check("busy_after", busy, 0);
        check_board(tag);
    endtask

    task automatic commit(input string tag, input int t, input logic [19:0] vv, input logic [19:0] hh);
        issue_commit(t, vv, hh);
        finish_commit(tag);
    endtask

    task automatic pulse_clear_all();
        @(negedge clk_25_175);
        clear_all = 1'b1;
        @(negedge clk_25_175);
        clear_all = 1'b0;
        model_zero();
    endtask

    // Row 10 columns 0..17 type 1, row 9 column 5 type 2
    task automatic prefill_row10();
        for (int c = 0; c < 16; c += 4) commit("prefill", 1, pk(10, 10, 10, 10), pk(c, c+1, c+2, c+3));
        commit("prefill", 1, pk(10, 10, 31, 31), pk(16, 17, 31, 31));
        commit("prefill", 2, pk(9, 31, 31, 31), pk(5, 31, 31, 31));
    endtask

    initial begin
        int c, it;
        int qv[$], qh[$];
        int a[4], b[4];
        reset = 1'b0; commit_valid = 1'b0; commit_type = 3'd0; commit_v = 20'd0; commit_h = 20'd0;
        clear_all = 1'b0; memselector_v = 5'd0; memselector_h = 5'd0;
        model_zero();
        repeat (3) @(posedge clk_25_175);
        @(negedge clk_25_175);
        reset = 1'b1;
        @(negedge clk_25_175);
        check("rst_ready", commit_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", clear_done, 0);
        check("rst_count", clear_count, 0);
        check_board("rst_board");

        commit("square", 3, pk(10, 10, 9, 9), pk(0, 1, 0, 1));
        check("square_latency", exp_latency, 15);

        pulse_clear_all();
        prefill_row10();
        commit("row10", 4, pk(10, 10, 10, 10), pk(18, 19, 20, 21));
        check("row10_count", clear_count, 1);
        memselector_v = 5'd10; memselector_h = 5'd5; #1;
        check("row10_drop", blocktype_mem, 2);

        pulse_clear_all();
        c = $urandom_range(0, 21);
        for (int r = 9; r <= 10; r++)
            for (int h = 0; h < 22; h++)
                if (h != c) begin qv.push_back(r); qh.push_back(h); end
        while (qv.size() > 0) begin
            for (int k = 0; k < 4; k++) begin
                a[k] = (qv.size() > 0) ? qv.pop_front() : 31;
                b[k] = (qh.size() > 0) ? qh.pop_front() : 31;
            end
            commit("fill", $urandom_range(1, 7), pk(a[0], a[1], a[2], a[3]), pk(b[0], b[1], b[2], b[3]));
        end
        commit("row8", 6, pk(8, 31, 31, 31), pk((c + 1) % 22, 31, 31, 31));
        commit("ipiece", $urandom_range(1, 7), pk(7, 8, 9, 10), pk(c, c, c, c));
        check("ipiece_count", clear_count, 2);

        commit("oob_cells", 5, pk(1, 3, 12, 4), pk(2, 4, 3, 25));

        for (it = 0; it < 30; it++) begin
            for (int k = 0; k < 4; k++) begin
                a[k] = $urandom_range(0, 12);
                b[k] = $urandom_range(0, 23);
            end
            commit("random", $urandom_range(0, 7), pk(a[0], a[1], a[2], a[3]), pk(b[0], b[1], b[2], b[3]));
        end
        repeat (3) @(negedge clk_25_175);
        check("count_hold", clear_count, exp_count);

        pulse_clear_all();
        prefill_row10();
        issue_commit(4, pk(10, 10, 10, 10), pk(18, 19, 20, 21));
        repeat (8) @(posedge clk_25_175);
        #5;
        check("shift_busy", busy, 1);
        reset = 1'b0;
        repeat (2) @(negedge clk_25_175);
        reset = 1'b1;
        model_zero();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_25_175);
            check("post_rst_no_done", clear_done, 0);
        end
        check("post_rst_ready", commit_ready, 1);
        check("post_rst_count", clear_count, 0);
        check_board("post_rst_board");

        commit("seed", 7, pk(5, 5, 6, 6), pk(3, 4, 3, 4));
        issue_commit(2, pk(10, 10, 10, 10), pk(0, 1, 2, 3));
        repeat (6) @(posedge clk_25_175);
        @(negedge clk_25_175);
        clear_all = 1'b1; commit_valid = 1'b1; commit_type = 3'd5;
        commit_v = pk(0, 0, 0, 0); commit_h = pk(0, 1, 2, 3);
        @(negedge clk_25_175);
        clear_all = 1'b0; commit_valid = 1'b0;
        model_zero();
        check("ca_busy", busy, 0);
        check("ca_ready", commit_ready, 1);
        check("ca_count", clear_count, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_25_175);
            check("ca_no_done", clear_done, 0);
            check("ca_idle", busy, 0);
        end
        check_board("ca_board");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
